// File: rtl/gpr_writeback_scheduler.sv
// Write-port arbiter and long-latency scoreboard for the 32x32 GPR file.
// Pipeline writeback normally wins the port; a starving long result forces a one-cycle pipeline hold.
module gpr_writeback_scheduler #(
    parameter int MAX_LONG     = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rs,
    input  logic [4:0]  issue_rt,
    input  logic [4:0]  issue_rd,
    input  logic        issue_long,
    output logic        issue_stall,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_value,
    input  logic [31:0] pipe_pc,
    output logic        pipe_hold,
    input  logic        long_valid,
    input  logic [4:0]  long_rd,
    input  logic [31:0] long_value,
    input  logic [31:0] long_pc,
    output logic        long_ready,
    output logic        gpr_we,
    output logic [4:0]  gpr_rd,
    output logic [31:0] gpr_value,
    output logic [31:0] gpr_pc
);

    localparam int CW = $clog2(MAX_LONG + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(MAX_LONG);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [31:0]   busy_r;
    logic [CW-1:0] out_cnt_r;
    logic [SW-1:0] starve_cnt_r;

    logic          stall_s;
    logic          starve_win_s;
    logic          pipe_win_s;
    logic          long_win_s;
    logic          long_issue_s;
    logic          long_done_s;
    logic [31:0]   set_mask_s;
    logic [31:0]   clr_mask_s;
    logic [31:0]   busy_nxt_s;
    logic [CW-1:0] cnt_nxt_s;
    logic [SW-1:0] starve_nxt_s;

    // Hazard check against the registered scoreboard only, so a same-cycle completion still stalls.
    always_comb begin
        stall_s = 1'b0;
        if (issue_valid) begin
            stall_s = busy_r[issue_rs] | busy_r[issue_rt] | busy_r[issue_rd] |
                      (issue_long & (out_cnt_r == CNT_MAX));
        end else begin
            stall_s = 1'b0;
        end
    end

    // Write-port arbitration: starvation override, then pipeline priority, then long unit.
    always_comb begin
        starve_win_s = 1'b0;
        pipe_win_s   = 1'b0;
        long_win_s   = 1'b0;
        if ((starve_cnt_r == STARVE_MAX) && long_valid) begin
            starve_win_s = 1'b1;
            long_win_s   = 1'b1;
        end else if (pipe_we) begin
            pipe_win_s   = 1'b1;
        end else begin
            long_win_s   = long_valid;
        end
    end

    // Register-file write mux driven by the arbitration winner.
    always_comb begin
        gpr_we    = 1'b0;
        gpr_rd    = 5'd0;
        gpr_value = 32'd0;
        gpr_pc    = 32'd0;
        if (long_win_s) begin
            gpr_we    = 1'b1;
            gpr_rd    = long_rd;
            gpr_value = long_value;
            gpr_pc    = long_pc;
        end else if (pipe_win_s) begin
            gpr_we    = 1'b1;
            gpr_rd    = pipe_rd;
            gpr_value = pipe_value;
            gpr_pc    = pipe_pc;
        end else begin
            gpr_we    = 1'b0;
        end
    end

    assign issue_stall  = stall_s;
    assign pipe_hold    = starve_win_s;
    assign long_ready   = long_win_s;
    assign long_issue_s = issue_valid & ~stall_s & issue_long;
    assign long_done_s  = long_valid & long_win_s;
    assign set_mask_s   = long_issue_s ? (32'h0000_0001 << issue_rd) : 32'h0000_0000;
    assign clr_mask_s   = long_done_s  ? (32'h0000_0001 << long_rd)  : 32'h0000_0000;
    // Register 0 never becomes busy, which is what lets rd=0 long ops skip the scoreboard.
    assign busy_nxt_s   = ((busy_r & ~clr_mask_s) | set_mask_s) & 32'hFFFF_FFFE;

    // Outstanding counter and starvation counter next-state.
    always_comb begin
        cnt_nxt_s    = out_cnt_r;
        starve_nxt_s = '0;
        if (long_issue_s && !long_done_s) begin
            cnt_nxt_s = out_cnt_r + CW'(1);
        end else if (!long_issue_s && long_done_s && (out_cnt_r != '0)) begin
            cnt_nxt_s = out_cnt_r - CW'(1);
        end else begin
            cnt_nxt_s = out_cnt_r;
        end
        if (long_valid && !long_win_s) begin
            starve_nxt_s = (starve_cnt_r == STARVE_MAX) ? starve_cnt_r : starve_cnt_r + SW'(1);
        end else begin
            starve_nxt_s = '0;
        end
    end

    // State registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_r       <= 32'd0;
            out_cnt_r    <= '0;
            starve_cnt_r <= '0;
        end else begin
            busy_r       <= busy_nxt_s;
            out_cnt_r    <= cnt_nxt_s;
            starve_cnt_r <= starve_nxt_s;
        end
    end

endmodule
